// File: rtl/crc16_frame_checker.sv
// crc16_frame_checker
//   Receive-side CRC16 frame checker (poly 1+x^5+x^12+x^16, init 0x0000).
//   Each frame is one or more payload words followed by one CRC word, which is
//   marked by data_last. The checker runs the CRC over the whole frame and
//   treats a zero residue as a pass. It also flags runt and overrun frames and
//   keeps saturating good/bad frame counters.
// Ports
//   clk_in, rst_n       clock, asynchronous active-low reset
//   data_in             frame word
//   data_valid          word valid this cycle (low = stall)
//   data_last           word is the CRC word (final word of frame)
//   clear_cnt           synchronous clear of good_cnt/bad_cnt
//   check_done          1-cycle pulse when the result outputs are updated
//   crc_ok/crc_err      last frame passed / failed the residue check (held)
//   len_err             last frame was a runt or an overrun (held)
//   crc_residue         final CRC state of last frame (held)
//   frame_len           words counted in last frame (held)
//   good_cnt/bad_cnt    saturating frame counters
module crc16_frame_checker #(
    parameter int unsigned MAX_WORDS = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic [15:0]                      data_in,
    input  logic                             data_valid,
    input  logic                             data_last,
    input  logic                             clear_cnt,
    output logic                             check_done,
    output logic                             crc_ok,
    output logic                             crc_err,
    output logic                             len_err,
    output logic [15:0]                      crc_residue,
    output logic [$clog2(MAX_WORDS+1)-1:0]   frame_len,
    output logic [CNT_W-1:0]                 good_cnt,
    output logic [CNT_W-1:0]                 bad_cnt
);

    localparam int unsigned CRC_W = 16;
    localparam int unsigned LEN_W = $clog2(MAX_WORDS + 1);
    localparam logic [CRC_W-1:0] POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Sixteen serial shifts of the CRC register, i.e. one full word.
    function automatic logic [CRC_W-1:0] s16(input logic [CRC_W-1:0] x);
        logic [CRC_W-1:0] r;
        r = x;
        for (int i = 0; i < 16; i++) begin
            r = {r[CRC_W-2:0], 1'b0} ^ (r[CRC_W-1] ? POLY : {CRC_W{1'b0}});
        end
        return r;
    endfunction

    state_t            state_q,   state_d;
    logic [CRC_W-1:0]  crc_q,     crc_d;
    logic [LEN_W-1:0]  cnt_q,     cnt_d;
    logic              done_q,    done_d;
    logic              ok_q,      ok_d;
    logic              err_q,     err_d;
    logic              len_q,     len_d;
    logic [CRC_W-1:0]  res_q,     res_d;
    logic [LEN_W-1:0]  flen_q,    flen_d;
    logic [CNT_W-1:0]  good_q,    good_d;
    logic [CNT_W-1:0]  bad_q,     bad_d;

    logic [CRC_W-1:0]  crc_upd_c;
    logic [LEN_W-1:0]  cnt_upd_c;
    logic              eval_c;
    logic              len_bad_c;

    // State register and held results.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= 1'b0;
            res_q   <= '0;
            flen_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            len_q   <= len_d;
            res_q   <= res_d;
            flen_q  <= flen_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state, CRC/count update, evaluation and counters.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ok_d      = ok_q;
        err_d     = err_q;
        len_d     = len_q;
        res_d     = res_q;
        flen_d    = flen_q;
        good_d    = good_q;
        bad_d     = bad_q;
        eval_c    = 1'b0;
        len_bad_c = 1'b0;

        // First word of a frame starts from a zero CRC and a count of one.
        if (state_q == ST_IDLE) begin
            crc_upd_c = s16(data_in);
            cnt_upd_c = LEN_W'(1);
        end else begin
            crc_upd_c = s16(crc_q ^ data_in);
            cnt_upd_c = cnt_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    crc_d = crc_upd_c;
                    cnt_d = cnt_upd_c;
                    if (data_last) begin
                        eval_c    = 1'b1;
                        len_bad_c = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (data_valid) begin
                    crc_d = crc_upd_c;
                    cnt_d = cnt_upd_c;
                    if (data_last) begin
                        eval_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cnt_upd_c == LEN_W'(MAX_WORDS)) begin
                        // Frame already at max length but no CRC word yet.
                        eval_c    = 1'b1;
                        len_bad_c = 1'b1;
                        state_d   = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (data_valid && data_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (eval_c) begin
            done_d = 1'b1;
            res_d  = crc_upd_c;
            flen_d = cnt_upd_c;
            len_d  = len_bad_c;
            ok_d   = !len_bad_c && (crc_upd_c == '0);
            err_d  = !len_bad_c && (crc_upd_c != '0);
        end

        // Clear wins over a same-cycle increment.
        if (clear_cnt) begin
            good_d = '0;
            bad_d  = '0;
        end else if (eval_c) begin
            if (ok_d) begin
                if (good_q != {CNT_W{1'b1}}) good_d = good_q + CNT_W'(1);
            end else begin
                if (bad_q != {CNT_W{1'b1}}) bad_d = bad_q + CNT_W'(1);
            end
        end
    end

    assign check_done  = done_q;
    assign crc_ok      = ok_q;
    assign crc_err     = err_q;
    assign len_err     = len_q;
    assign crc_residue = res_q;
    assign frame_len   = flen_q;
    assign good_cnt    = good_q;
    assign bad_cnt     = bad_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
module tb_crc16_frame_checker;

    localparam int unsigned MAX_WORDS = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned LEN_W     = $clog2(MAX_WORDS + 1);
    localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [15:0]       data_in;
    logic              data_valid;
    logic              data_last;
    logic              clear_cnt;
    logic              check_done;
    logic              crc_ok;
    logic              crc_err;
    logic              len_err;
    logic [15:0]       crc_residue;
    logic [LEN_W-1:0]  frame_len;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  bad_cnt;

    crc16_frame_checker #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_last   (data_last),
        .clear_cnt   (clear_cnt),
        .check_done  (check_done),
        .crc_ok      (crc_ok),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .crc_residue (crc_residue),
        .frame_len   (frame_len),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [15:0] frame_q[$];
    bit          dropping;
    bit          e_done, e_ok, e_err, e_len;
    logic [15:0] e_res;
    int          e_flen, e_good, e_bad;

    // w * x^16 mod P over GF(2), by long division of a 32-bit polynomial.
    function automatic logic [15:0] mulx16(input logic [15:0] x);
        logic [31:0] v;
        v = {x, 16'h0000};
        for (int b = 31; b >= 16; b--)
            if (v[b]) v = v ^ (32'h0001_1021 << (b - 16));
        return v[15:0];
    endfunction

    function automatic logic [15:0] frame_crc();
        logic [15:0] c;
        c = 16'h0000;
        foreach (frame_q[i]) c = mulx16(c ^ frame_q[i]);
        return c;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        dropping = 0;
        e_done = 0; e_ok = 0; e_err = 0; e_len = 0;
        e_res = 16'h0; e_flen = 0; e_good = 0; e_bad = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit l, input bit c);
        e_done = 0;
        if (v) begin
            if (dropping) begin
                if (l) dropping = 0;
            end else begin
                frame_q.push_back(d);
                if (l || frame_q.size() == MAX_WORDS) begin
                    e_done = 1;
                    e_flen = frame_q.size();
                    e_res  = frame_crc();
                    if ((l && frame_q.size() == 1) || !l) begin
                        e_len = 1; e_ok = 0; e_err = 0;
                    end else begin
                        e_len = 0; e_ok = (e_res == 16'h0); e_err = !e_ok;
                    end
                    if (!l) dropping = 1;
                    frame_q.delete();
                end
            end
        end
        if (c) begin
            e_good = 0; e_bad = 0;
        end else if (e_done) begin
            if (e_ok) e_good = (e_good == CNT_MAX) ? e_good : e_good + 1;
            else      e_bad  = (e_bad  == CNT_MAX) ? e_bad  : e_bad  + 1;
        end
    endtask

    task automatic check_model();
        chk("done",  check_done,  e_done);
        chk("ok",    crc_ok,      e_ok);
        chk("err",   crc_err,     e_err);
        chk("len",   len_err,     e_len);
        chk("res",   crc_residue, e_res);
        chk("flen",  frame_len,   e_flen);
        chk("good",  good_cnt,    e_good);
        chk("bad",   bad_cnt,     e_bad);
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic drive(input bit v, input logic [15:0] d, input bit l, input bit c);
        data_valid = v; data_in = d; data_last = l; clear_cnt = c;
        @(posedge clk_in);
        #1;
        model_step(v, d, l, c);
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit l, input bit c);
        drive(v, d, l, c);
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, check_done, 0);
        chk({tag, "_ok"},   crc_ok,     0);
        chk({tag, "_err"},  crc_err,    0);
        chk({tag, "_len"},  len_err,    0);
        chk({tag, "_res"},  crc_residue, 0);
        chk({tag, "_flen"}, frame_len,  0);
        chk({tag, "_good"}, good_cnt,   0);
        chk({tag, "_bad"},  bad_cnt,    0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          v;
        logic [15:0] d;
        bit          l;
        bit          c;
        bit          done, ok, err, len;
        logic [15:0] res;
        int          flen, good, bad;
    } vec_t;

    function automatic vec_t mk(bit v, logic [15:0] d, bit l, bit c, bit done, bit ok,
                                bit err, bit len, logic [15:0] res, int flen, int good, int bad);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.c = c; t.done = done; t.ok = ok; t.err = err;
        t.len = len; t.res = res; t.flen = flen; t.good = good; t.bad = bad;
        return t;
    endfunction

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(1, 16'h0001, 0, 0,  0, 0, 0, 0, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(1, 16'h1021, 1, 0,  1, 1, 0, 0, 16'h0000, 2, 1, 0);
        tbl[2]  = mk(1, 16'h0002, 0, 0,  0, 1, 0, 0, 16'h0000, 2, 1, 0);
        tbl[3]  = mk(1, 16'h2042, 1, 0,  1, 1, 0, 0, 16'h0000, 2, 2, 0);
        tbl[4]  = mk(1, 16'h0001, 0, 0,  0, 1, 0, 0, 16'h0000, 2, 2, 0);
        tbl[5]  = mk(1, 16'h1020, 1, 0,  1, 0, 1, 0, 16'h1021, 2, 2, 1);
        tbl[6]  = mk(1, 16'h1234, 1, 0,  1, 0, 0, 1, 16'h13C6, 1, 2, 2);
        tbl[7]  = mk(0, 16'hFFFF, 1, 0,  0, 0, 0, 1, 16'h13C6, 1, 2, 2);
        tbl[8]  = mk(1, 16'h0001, 0, 0,  0, 0, 0, 1, 16'h13C6, 1, 2, 2);
        tbl[9]  = mk(1, 16'h1021, 1, 1,  1, 1, 0, 0, 16'h0000, 2, 0, 0);
        tbl[10] = mk(0, 16'h0000, 0, 0,  0, 1, 0, 0, 16'h0000, 2, 0, 0);

        rst_n = 1'b0; data_in = '0; data_valid = 0; data_last = 0; clear_cnt = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed table: pass, back-to-back pass, crc error, runt, stall, clear.
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c);
            chk($sformatf("tbl%0d_done", i), check_done,  tbl[i].done);
            chk($sformatf("tbl%0d_ok", i),   crc_ok,      tbl[i].ok);
            chk($sformatf("tbl%0d_err", i),  crc_err,     tbl[i].err);
            chk($sformatf("tbl%0d_len", i),  len_err,     tbl[i].len);
            chk($sformatf("tbl%0d_res", i),  crc_residue, tbl[i].res);
            chk($sformatf("tbl%0d_flen", i), frame_len,   tbl[i].flen);
            chk($sformatf("tbl%0d_good", i), good_cnt,    tbl[i].good);
            chk($sformatf("tbl%0d_bad", i),  bad_cnt,     tbl[i].bad);
        end

        // Overrun: 6 words with last on word 6, MAX_WORDS=4.
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 0, 0);
        step(1, 16'h3333, 0, 0);
        step(1, 16'h4444, 0, 0);
        chk("ovr_done", check_done, 1);
        chk("ovr_len",  len_err,    1);
        chk("ovr_flen", frame_len,  4);
        chk("ovr_ok",   crc_ok,     0);
        step(1, 16'h5555, 0, 0);
        chk("drop5_done", check_done, 0);
        step(0, 16'h0000, 1, 0);
        step(1, 16'h6666, 1, 0);
        chk("drop6_done", check_done, 0);
        step(1, 16'h0001, 0, 0);
        step(1, 16'h1021, 1, 0);
        chk("after_drop_ok", crc_ok, 1);
        chk("after_drop_done", check_done, 1);

        // Stalls between words do not affect the frame.
        step(1, 16'h0001, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 16'hDEAD, 0, 0);
            chk("stall_done", check_done, 0);
        end
        step(1, 16'h1021, 1, 0);
        chk("stall_ok",   crc_ok,    1);
        chk("stall_flen", frame_len, 2);

        // Reset mid-frame: frame abandoned, no done, outputs cleared.
        step(1, 16'hABCD, 0, 0);
        step(1, 16'h0001, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all_zero("midrst");
        @(posedge clk_in);
        #2;
        rst_n = 1'b1;
        step(0, 16'h0000, 0, 0);
        chk("midrst_nodone", check_done, 0);

        // Good counter saturation.
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            step(1, 16'h0001, 0, 0);
            step(1, 16'h1021, 1, 0);
        end
        chk("sat_good", good_cnt, CNT_MAX);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bit          v, l, c;
            logic [15:0] d;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 49) == 0);
            d = 16'($urandom);
            if (v && l && !dropping && frame_q.size() > 0 && $urandom_range(0, 1) == 1)
                d = frame_crc();
            step(v, d, l, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
